axil_slave_adapter: RTL
=======================

Name: axil_slave_adapter

Overview:
AXI4-lite slave (responder) that terminates an AXI4-lite bus and drives a simple single-outstanding memory/register port (mem_val/mem_accept handshake). It sits in front of on-chip RAMs and peripheral register files that are reached through the core's AXI4-lite master adapter. One transaction is in flight on the memory side at a time. Reads and writes are arbitrated round-robin.

Parameters:
ADDR_W, 32, address width on AXI and memory sides
TIMEOUT, 0, max cycles waiting for mem_accept; 0 = no timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
axi_awvalid  in  1  write address valid
axi_awready  out  1  write address ready
axi_awaddr  in  ADDR_W  write address
axi_wvalid  in  1  write data valid
axi_wready  out  1  write data ready
axi_wdata  in  32  write data
axi_wstrb  in  4  byte strobes
axi_bvalid  out  1  write response valid
axi_bready  in  1  write response ready
axi_bresp  out  2  00 OKAY, 10 SLVERR
axi_arvalid  in  1  read address valid
axi_arready  out  1  read address ready
axi_araddr  in  ADDR_W  read address
axi_rvalid  out  1  read data valid
axi_rready  in  1  read data ready
axi_rdata  out  32  read data
axi_rresp  out  2  00 OKAY, 10 SLVERR
mem_val  out  1  memory request valid, held until mem_accept
mem_accept  in  1  request complete; mem_rdata/mem_error valid this cycle
mem_addr  out  ADDR_W  request address
mem_wdata  out  32  write data
mem_wen  out  4  byte write enables (0 on reads)
mem_ren  out  1  read request
mem_rdata  in  32  read data
mem_error  in  1  access error

Behaviour:
- Reset is asynchronous and active-low: clk, rst_n. Asserting rst_n low clears all holding registers and flags, state=IDLE, arb pointer=write-first. Outputs during/after reset: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, mem_val=0, mem_wen=0, mem_ren=0. Reset mid-transaction abandons it silently; no response is issued.
- Capture: separate AW, W and AR holding registers, each with a full flag. Xready = !X_full. X_full is set on Xvalid&&Xready and cleared when the response for that transaction completes. AW and W are independent: either order or same cycle.
- States: IDLE, WR_MEM, RD_MEM, WR_RESP, RD_RESP.
- IDLE arbitration: wr_rdy = aw_full&&w_full; rd_rdy = ar_full.
  - Only one ready: that one is granted.
  - Both ready: grant the type not served last (pointer toggles on each grant).
  - Grant evaluates registered flags, so data accepted in cycle N can be granted at cycle N+1 at the earliest.
- Zero-strobe write (wstrb==0): no memory access; go directly to WR_RESP with OKAY.
- WR_MEM/RD_MEM: mem_val=1; mem_addr, mem_wdata and mem_wen come from the holding registers (reads: mem_ren=1, mem_wen=0). On mem_accept: latch resp = mem_error ? 10 : 00 and latch rdata for reads; deassert mem_val next cycle; go to the matching RESP state.
- Timeout: when TIMEOUT>0, a cycle counter runs in the MEM states. If the count reaches TIMEOUT-1 with no accept, drop mem_val, set resp=10, rdata=0, and go to RESP. A mem_accept in that same cycle wins over the timeout.
- WR_RESP: bvalid=1 with bresp stable until bready. On handshake: clear aw_full and w_full, go to IDLE. RD_RESP is the same with rvalid/rdata/rresp/rready, clearing ar_full.
- Minimum latency: AW+W accepted in cycle 0 -> mem_val in cycle 1 -> with same-cycle accept, bvalid in cycle 2. Read latency is identical.
- A new AW/W or AR can be captured while the other type is in flight. The same type cannot be captured until its response completes.

Test Plan:
- AW(0x100) in cycle 0, W(0xDEADBEEF, strb F) in cycle 3, mem_accept same cycle as mem_val -> one mem write with addr 0x100, wen F, data DEADBEEF; bvalid 2 cycles after W; bresp 00.
- W before AW, and AW+W in the same cycle, with bready held low 5 cycles -> bvalid/bresp stable throughout; awready/wready stay low until the B handshake.
- Read 0x40 with mem_rdata=0x12345678 and mem_accept delayed 3 cycles -> mem_val held 4 cycles, mem_ren=1, mem_wen=0; rdata 12345678, rresp 00.
- Write and read both pending in IDLE, repeated 4 times -> granted order alternates W,R,W,R; no lost or duplicated mem accesses.
- mem_error=1 on accept -> resp 10. TIMEOUT=8 with mem_accept never asserted -> mem_val drops after 8 cycles; rresp 10, rdata 0.
- wstrb=0 write -> no mem_val, bresp 00. Then assert rst_n low while in RD_MEM -> all valids low immediately, readies high, and no stale response after reset.

Source files
------------

// File: rtl/axil_slave_adapter.sv
// AXI4-lite slave that serialises reads and writes onto a single-outstanding
// mem_val/mem_accept port, with round-robin read/write arbitration and optional timeout.
module axil_slave_adapter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              axi_awvalid,
  output logic              axi_awready,
  input  logic [ADDR_W-1:0] axi_awaddr,
  input  logic              axi_wvalid,
  output logic              axi_wready,
  input  logic [31:0]       axi_wdata,
  input  logic [3:0]        axi_wstrb,
  output logic              axi_bvalid,
  input  logic              axi_bready,
  output logic [1:0]        axi_bresp,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  input  logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_rvalid,
  input  logic              axi_rready,
  output logic [31:0]       axi_rdata,
  output logic [1:0]        axi_rresp,
  output logic              mem_val,
  input  logic              mem_accept,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wen,
  output logic              mem_ren,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_error
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, WR_MEM, RD_MEM, WR_RESP, RD_RESP} state_e;

  state_e             state_q, state_d;
  logic               aw_full_q, w_full_q, ar_full_q;
  logic [ADDR_W-1:0]  aw_addr_q, ar_addr_q;
  logic [31:0]        w_data_q;
  logic [3:0]         w_strb_q;
  logic               prefer_wr_q;
  logic [1:0]         resp_q;
  logic [31:0]        rdata_q;
  logic [CNT_W-1:0]   cnt_q, cnt_cur;

  logic grant_wr, grant_rd, mem_act, mem_rd, mem_done, timeout_hit;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign axi_awready = !aw_full_q;
  assign axi_wready  = !w_full_q;
  assign axi_arready = !ar_full_q;
  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid && axi_wready;
  assign ar_hs = axi_arvalid && axi_arready;
  assign b_hs  = (state_q == WR_RESP) && axi_bready;
  assign r_hs  = (state_q == RD_RESP) && axi_rready;

  // The grant cycle itself already drives the request, so its cycle count is zero.
  assign cnt_cur     = (state_q == IDLE) ? '0 : cnt_q;
  assign timeout_hit = (TIMEOUT > 0) && (cnt_cur == CNT_LAST);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    mem_act  = 1'b0;
    mem_rd   = 1'b0;
    case (state_q)
      IDLE: begin
        grant_wr = aw_full_q && w_full_q && (!ar_full_q || prefer_wr_q);
        grant_rd = ar_full_q && !grant_wr;
        if (grant_wr) begin
          if (w_strb_q == 4'h0) begin
            state_d = WR_RESP;
          end else begin
            mem_act = 1'b1;
            state_d = WR_MEM;
          end
        end else if (grant_rd) begin
          mem_act = 1'b1;
          mem_rd  = 1'b1;
          state_d = RD_MEM;
        end
      end
      WR_MEM:  mem_act = 1'b1;
      RD_MEM: begin
        mem_act = 1'b1;
        mem_rd  = 1'b1;
      end
      WR_RESP: if (axi_bready) state_d = IDLE;
      RD_RESP: if (axi_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_done = mem_act && (mem_accept || timeout_hit);
    if (mem_done) state_d = mem_rd ? RD_RESP : WR_RESP;
  end

  assign mem_val    = mem_act;
  assign mem_ren    = mem_act && mem_rd;
  assign mem_wen    = (mem_act && !mem_rd) ? w_strb_q : 4'h0;
  assign mem_addr   = mem_rd ? ar_addr_q : aw_addr_q;
  assign mem_wdata  = w_data_q;
  assign axi_bvalid = (state_q == WR_RESP);
  assign axi_bresp  = axi_bvalid ? resp_q : RESP_OKAY;
  assign axi_rvalid = (state_q == RD_RESP);
  assign axi_rresp  = axi_rvalid ? resp_q : RESP_OKAY;
  assign axi_rdata  = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prefer_wr_q <= 1'b1;
      resp_q      <= RESP_OKAY;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      state_q <= state_d;
      if (grant_wr)      prefer_wr_q <= 1'b0;
      else if (grant_rd) prefer_wr_q <= 1'b1;
      if (mem_act && !mem_done) cnt_q <= cnt_cur + 1'b1;
      else                      cnt_q <= '0;
      if (grant_wr && (w_strb_q == 4'h0)) resp_q <= RESP_OKAY;
      if (mem_done) begin
        // An accept in the timeout cycle takes priority over the timeout.
        resp_q <= (!mem_accept || mem_error) ? RESP_SLVERR : RESP_OKAY;
        if (mem_rd) rdata_q <= mem_accept ? mem_rdata : '0;
      end
    end
  end

  // Holding registers are small flops, not RAM, so they are cleared on reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= axi_awaddr;
      end else if (b_hs) begin
        aw_full_q <= 1'b0;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= axi_wdata;
        w_strb_q <= axi_wstrb;
      end else if (b_hs) begin
        w_full_q <= 1'b0;
      end
      if (ar_hs) begin
        ar_full_q <= 1'b1;
        ar_addr_q <= axi_araddr;
      end else if (r_hs) begin
        ar_full_q <= 1'b0;
      end
    end
  end

endmodule
